// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide execution unit
//
// Sits behind the register file read ports. Takes two source operands,
// runs one radix-2 step per clock and returns the result together with its
// destination register index for write-back.
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   issue strobe, sampled only while idle
//   kill    in   synchronous abort of the in-flight op (also blocks an issue)
//   op      in   funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   src_a   in   rs1 value (multiplicand / dividend)
//   src_b   in   rs2 value (multiplier / divisor)
//   rd_in   in   destination register index for this op
//   busy    out  high whenever an op is in flight
//   done    out  one-cycle completion pulse; result/rd_out valid while high
//   result  out  registered result, held until the next completion
//   rd_out  out  registered destination index paired with result

module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  kill,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic [ADDR_WIDTH-1:0] rd_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [ADDR_WIDTH-1:0] rd_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [CW-1:0]         cnt;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / growing quotient}.
    logic [2*W-1:0]        acc;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [W-1:0]          opnd;
    logic                  neg_main;   // negate product / quotient
    logic                  neg_rem;    // negate remainder (dividend sign)
    logic                  div_zero;   // divide by zero: quotient forced all-ones

    logic issue;
    logic last_step;

    assign issue     = (state == S_IDLE) && start && !kill;
    assign last_step = (cnt == CW'(W - 1));

    // ------------------------------------------------------------------
    // Issue-time operand conditioning
    // ------------------------------------------------------------------
    logic           a_signed, b_signed;
    logic           sa, sb;
    logic [W-1:0]   mag_a, mag_b;

    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) ||
                   (op == OP_DIV)  || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        sa       = a_signed && src_a[W-1];
        sb       = b_signed && src_b[W-1];
        mag_a    = sa ? (~src_a + 1'b1) : src_a;
        mag_b    = sb ? (~src_b + 1'b1) : src_b;
    end

    // ------------------------------------------------------------------
    // One radix-2 step
    // ------------------------------------------------------------------
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_trial;
    logic [2*W-1:0] div_next;

    always_comb begin
        // Shift-add: add multiplicand into the high half when the current
        // multiplier bit (acc LSB) is set, then shift the whole thing right.
        mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
        mul_next = {mul_sum, acc[W-1:1]};
        // Restoring divide: trial-subtract the divisor from the remainder
        // shifted left by one with the next dividend bit; keep it if it
        // does not go negative and shift in a quotient one.
        div_trial = acc[2*W-1:W-1] - {1'b0, opnd};
        if (div_trial[W]) begin
            div_next = {acc[2*W-2:0], 1'b0};
        end else begin
            div_next = {div_trial[W-1:0], acc[W-2:0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and result selection (used on the FINISH edge)
    // ------------------------------------------------------------------
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   res_sel;

    always_comb begin
        prod_fix = neg_main ? (~acc + 1'b1) : acc;
        if (div_zero) begin
            quo_fix = {W{1'b1}};
        end else begin
            quo_fix = neg_main ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
        end
        // With a zero divisor the remainder magnitude ends up as |a|, so the
        // dividend-sign correction alone reproduces the original dividend.
        rem_fix = neg_rem ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
        case (op_q)
            OP_MUL:                       res_sel = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_sel = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:              res_sel = quo_fix;
            OP_REM, OP_REMU:              res_sel = rem_fix;
            default:                      res_sel = {W{1'b0}};
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    state_nx = S_CALC;
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_nx = S_IDLE;
                end else if (last_step) begin
                    state_nx = S_FINISH;
                end
            end
            S_FINISH: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 3'd0;
            rd_q     <= {ADDR_WIDTH{1'b0}};
            cnt      <= {CW{1'b0}};
            acc      <= {2*W{1'b0}};
            opnd     <= {W{1'b0}};
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            result   <= {W{1'b0}};
            rd_out   <= {ADDR_WIDTH{1'b0}};
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        op_q     <= op;
                        rd_q     <= rd_in;
                        cnt      <= {CW{1'b0}};
                        neg_main <= sa ^ sb;
                        neg_rem  <= sa;
                        div_zero <= op[2] && (src_b == {W{1'b0}});
                        if (op[2]) begin
                            acc  <= {{W{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
                            acc  <= {{W{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                    end
                end
                S_CALC: begin
                    if (!kill) begin
                        acc <= op_q[2] ? div_next : mul_next;
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FINISH: begin
                    if (!kill) begin
                        result <= res_sel;
                        rd_out <= rd_q;
                        done   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with a reference model
module tb_muldiv_unit;

    localparam int W = 32;
    localparam int A = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         kill;
    logic [2:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [A-1:0] rd_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [A-1:0] rd_out;

    muldiv_unit #(.DATA_WIDTH(W), .ADDR_WIDTH(A)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [A-1:0] rd;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] last_res = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the RV32M definitions.
    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint       sa, sbv, ua, ub;
        logic [63:0]  p;
        logic         ovf;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = ua * ub;  return p[31:0];  end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                if (ovf) return a;
                p = sa / sbv; return p[31:0];
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return '0;
                p = sa % sbv; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: pops the scoreboard on every completion pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got result %0h rd %0d expected no completion (t=%0t)",
                             result, rd_out, $time);
                end else begin
                    e = sb.pop_front();
                    check("result", 64'(result), 64'(e.res));
                    check("rd_out", 64'(rd_out), 64'(e.rd));
                    check("latency", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    // Waits until idle (bounded), then issues one op. The issue edge is the
    // next posedge; completion is seen W+2 counted edges from the drive point.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [A-1:0] rd, input bit expect_done);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 within 200 cycles");
        end
        op    = o;
        src_a = a;
        src_b = b;
        rd_in = rd;
        start = 1'b1;
        if (expect_done) begin
            e.res    = model(o, a, b);
            e.rd     = rd;
            e.due    = cyc + W + 2;
            last_res = e.res;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        rd_in = A'($urandom);
        op    = 3'($urandom);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t;
        rst_n = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        op    = '0;
        src_a = '0;
        src_b = '0;
        rd_in = '0;
        #12;
        check("reset_busy",   64'(busy),   64'd0);
        check("reset_done",   64'(done),   64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_rd_out", 64'(rd_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases; each issue lands back-to-back on the prior DONE cycle.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1);
        @(negedge clk);
        check("busy_after_issue", 64'(busy), 64'd1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd2, 1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd3, 1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd4, 1);
        issue(3'd5, 32'd100,       32'd7,         5'd6, 1);
        issue(3'd5, 32'h1234,      32'd0,         5'd7, 1);
        issue(3'd7, 32'h1234,      32'd0,         5'd8, 1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd0,         5'd11, 1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd0,         5'd12, 1);

        // Kill mid-operation; a START while busy must be ignored.
        issue(3'd4, 32'd1000, 32'd3, 5'd13, 0);
        repeat (9) @(negedge clk);
        op = 3'd0; src_a = 32'd9; src_b = 32'd9; rd_in = 5'd14; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignores_start", 64'(busy), 64'd1);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_result_held", 64'(result), 64'(last_res));
        repeat (40) @(negedge clk);
        issue(3'd0, 32'd3, 32'd4, 5'd15, 1);

        // KILL with START in IDLE: nothing issues.
        t = 0;
        @(negedge clk);
        while (busy && t < 200) begin @(negedge clk); t++; end
        op = 3'd0; src_a = 32'd5; src_b = 32'd5; rd_in = 5'd16;
        start = 1'b1; kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start_idle", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-operation.
        issue(3'd0, 32'd11, 32'd13, 5'd17, 0);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",   64'(busy),   64'd0);
        check("arst_done",   64'(done),   64'd0);
        check("arst_result", 64'(result), 64'd0);
        check("arst_rd_out", 64'(rd_out), 64'd0);
        #1 rst_n = 1'b1;
        last_res = '0;
        repeat (40) @(negedge clk);

        // Randomized ops with corner-biased operands.
        for (int i = 0; i < 30; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick(), A'($urandom_range(0, 31)), 1);
        end

        t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit sitting directly downstream of the register file read ports.
- Consumes the two source operands (the RD1/RD2 values), computes over a fixed number of cycles, and returns the result with its destination register index for write-back into the register file write port (WD3/A3, WE3).
- Issue/completion uses a START/BUSY/DONE handshake; the core stalls while BUSY is high.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and >= 8.
- ADDR_WIDTH, 5, destination register index width.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  issue strobe; sampled only in IDLE.
- KILL  input  1  synchronous abort of the in-flight operation (pipeline flush).
- OP  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- SRC_A  input  DATA_WIDTH  rs1 value (multiplicand/dividend).
- SRC_B  input  DATA_WIDTH  rs2 value (multiplier/divisor).
- RD_IN  input  ADDR_WIDTH  destination register index for this op.
- BUSY  output  1  high whenever state != IDLE.
- DONE  output  1  one-cycle pulse; RESULT/RD_OUT are valid while it is high.
- RESULT  output  DATA_WIDTH  registered result; holds its value until the next completion.
- RD_OUT  output  ADDR_WIDTH  registered destination index paired with RESULT.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; BUSY=0, DONE=0, RESULT=0, RD_OUT=0; counter and internal accumulators cleared. Reset mid-operation discards the op; no DONE is produced.
- States: IDLE -> CALC -> FINISH -> IDLE.
- IDLE, START=1 at edge E0:
  - Latch OP, RD_IN, and the operand magnitudes. Signed operands are DIV/REM both, MULH both, MULHSU SRC_A only.
  - Record result sign flags; clear counter; go to CALC.
- CALC: one radix-2 step per edge; counter increments; after DATA_WIDTH steps go to FINISH.
  - Multiply: shift-add on a 2*DATA_WIDTH product.
  - Divide: restoring shift-subtract.
- FINISH (one edge):
  - Apply sign correction (two's complement) and select the result:
    - MUL: low half of the product.
    - MULH/MULHSU/MULHU: high half of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Write RESULT and RD_OUT; DONE=1 in the following cycle only; state returns to IDLE.
- Fixed latency: DONE is high in the cycle after edge E0+DATA_WIDTH+1 (33 cycles after the issue edge at default). Special cases do not shorten it.
- Remainder sign follows the dividend; quotient truncates toward zero.
- Divide by zero (SRC_B=0): DIV/DIVU result all-ones; REM/REMU result = SRC_A.
- Signed overflow (DIV/REM, SRC_A=most-negative, SRC_B=-1): DIV result = SRC_A; REM result = 0.
- START while BUSY: ignored; operands are not re-latched.
- START in the same cycle DONE is high: accepted, since state is already IDLE (back-to-back issue).
- KILL=1 in CALC or FINISH: state goes to IDLE at the next edge; no DONE; RESULT/RD_OUT keep their previous values.
- KILL in IDLE with START: KILL wins and nothing is issued.
- Operand inputs may change freely after E0.

Test Plan:
- Reset, then MUL SRC_A=7, SRC_B=0xFFFFFFFD (-3), RD_IN=5 -> BUSY for 33 cycles; single DONE pulse; RESULT=0xFFFFFFEB, RD_OUT=5.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> RESULT=0xFFFFFFFE. Then MULHSU 0xFFFFFFFF (-1) x 2 issued back-to-back on the DONE cycle -> RESULT=0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. Then REM of the same operands -> 0xFFFFFFFF. Then DIVU 100/7 -> 14.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF; REMU 0x1234 / 0 -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Each completes in 33 cycles.
- Issue DIV, pulse START with new operands at cycle 10, then KILL at cycle 20 -> no DONE; RESULT unchanged. A following MUL 3x4 -> 12.
- Issue MUL, drop RST_N for 1 ns at cycle 15 -> BUSY/DONE/RESULT/RD_OUT immediately 0; no DONE afterwards.
